// File: rtl/multicycle_control.sv
// multicycle_control: FSM sequencing a multicycle MIPS-subset datapath.
// Ports:
//   clk, reset            - single clock, synchronous active-high reset
//   opcode[5:0]           - Instr[31:26], sampled in DECODE and MEMADR
//   zero                  - ALU zero flag, gates PCEn while branching
//   mem_ready             - memory completes the current access this cycle
//   IorD..PCWrite         - 1-bit datapath controls
//   ALUSrcB, ALUOp, PCSrc - 2-bit mux/ALU selects
//   PCEn                  - PC load enable
//   illegal_op            - pulses in DECODE for an unsupported opcode
//   state[3:0]            - current state encoding, for debug
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic       Branch,
    output logic       PCWrite,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic       illegal_op,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3,
        MEMWB = 4'd4, MEMWR = 4'd5, EXECUTE = 4'd6, ALUWB = 4'd7,
        BRANCH = 4'd8, ADDIEX = 4'd9, ADDIWB = 4'd10, JUMP = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000,
                           OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;

    state_t cur;

    always_ff @(posedge clk)
        if (reset) cur <= FETCH;
        else case (cur)
            FETCH:   if (mem_ready) cur <= DECODE;
            DECODE:  case (opcode)
                         OP_LW, OP_SW: cur <= MEMADR;
                         OP_R:         cur <= EXECUTE;
                         OP_BEQ:       cur <= BRANCH;
                         OP_ADDI:      cur <= ADDIEX;
                         OP_J:         cur <= JUMP;
                         default:      cur <= FETCH;
                     endcase
            MEMADR:  cur <= (opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   if (mem_ready) cur <= MEMWB;
            MEMWR:   if (mem_ready) cur <= FETCH;
            EXECUTE: cur <= ALUWB;
            ADDIEX:  cur <= ADDIWB;
            default: cur <= FETCH;
        endcase

    // Everything is gated by reset so the datapath sees no writes while it is held.
    always_comb begin
        {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, Branch, PCWrite} = '0;
        ALUSrcB = 2'b00;
        ALUOp = 2'b00;
        PCSrc = 2'b00;
        illegal_op = 1'b0;
        if (!reset) case (cur)
            FETCH:   begin ALUSrcB = 2'b01; IRWrite = mem_ready; PCWrite = mem_ready; end
            DECODE:  begin
                ALUSrcB = 2'b11;
                illegal_op = !(opcode inside {OP_LW, OP_SW, OP_R, OP_BEQ, OP_ADDI, OP_J});
            end
            MEMADR:  begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
            MEMRD:   IorD = 1'b1;
            MEMWB:   begin MemtoReg = 1'b1; RegWrite = 1'b1; end
            MEMWR:   begin IorD = 1'b1; MemWrite = 1'b1; end
            EXECUTE: begin ALUSrcA = 1'b1; ALUOp = 2'b10; end
            ALUWB:   begin RegDst = 1'b1; RegWrite = 1'b1; end
            BRANCH:  begin ALUSrcA = 1'b1; ALUOp = 2'b01; PCSrc = 2'b01; Branch = 1'b1; end
            ADDIEX:  begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
            ADDIWB:  RegWrite = 1'b1;
            JUMP:    begin PCSrc = 2'b10; PCWrite = 1'b1; end
            default: ;
        endcase
    end

    assign PCEn  = PCWrite | (Branch & zero);
    assign state = reset ? 4'd0 : cur;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed table plus random checks of multicycle_control against a plan-queue model.
module tb_multicycle_control;
    logic clk = 1'b0, reset = 1'b1, zero = 1'b0, mem_ready = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, Branch, PCWrite, PCEn, illegal_op;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic [3:0] state;
    logic [20:0] act;
    int checks = 0, errors = 0;
    int plan[$];

    typedef struct {
        logic r;
        logic [5:0] op;
        logic z, mr;
        logic [3:0] st, we;
        logic pcen, ill;
    } vec_t;
    vec_t tbl[$];

    localparam logic [5:0] LW = 6'h23, SW = 6'h2B, RT = 6'h00, BEQ = 6'h04, ADDI = 6'h08, J = 6'h02, BAD = 6'h3F;

    multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .Branch(Branch), .PCWrite(PCWrite),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .PCEn(PCEn), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    assign act = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, Branch, PCWrite,
                  ALUSrcB, ALUOp, PCSrc, PCEn, illegal_op, state};

    function automatic bit legal(input logic [5:0] op);
        return op == LW || op == SW || op == RT || op == BEQ || op == ADDI || op == J;
    endfunction

    // Output table per state, written straight from the control listing.
    function automatic logic [20:0] expw(input int st, input logic r, input logic [5:0] op, input logic z, input logic mr);
        logic iord = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, sa = 0, br = 0, pcw = 0, ill = 0;
        logic [1:0] sb = 0, ao = 0, ps = 0;
        if (r) return 21'd0;
        case (st)
            0:  begin sb = 1; irw = mr; pcw = mr; end
            1:  begin sb = 3; ill = !legal(op); end
            2:  begin sa = 1; sb = 2; end
            3:  iord = 1;
            4:  begin m2r = 1; rw = 1; end
            5:  begin iord = 1; mw = 1; end
            6:  begin sa = 1; ao = 2; end
            7:  begin rd = 1; rw = 1; end
            8:  begin sa = 1; ao = 1; ps = 1; br = 1; end
            9:  begin sa = 1; sb = 2; end
            10: rw = 1;
            11: begin ps = 2; pcw = 1; end
            default: ;
        endcase
        return {iord, mw, irw, rd, m2r, rw, sa, br, pcw, sb, ao, ps, pcw | (br & z), ill, 4'(st)};
    endfunction

    // Model: a queue of upcoming states; waits hold the head, and an instruction's route is queued once known.
    task automatic model_step(input logic r, input logic [5:0] op, input logic mr);
        int c;
        if (r) begin plan = {0}; return; end
        c = plan[0];
        if ((c == 0 || c == 3 || c == 5) && !mr) return;
        void'(plan.pop_front());
        if (plan.size() != 0) return;
        if (c == 0) plan = {1};
        else if (c == 1) begin
            if (op == LW || op == SW) plan = {2};
            else if (op == RT) plan = {6, 7};
            else if (op == BEQ) plan = {8};
            else if (op == ADDI) plan = {9, 10};
            else if (op == J) plan = {11};
            else plan = {0};
        end
        else if (c == 2) plan = (op == SW) ? {5} : {3, 4};
        else plan = {0};
    endtask

    task automatic drive(input logic r, input logic [5:0] op, input logic z, input logic mr);
        reset = r; opcode = op; zero = z; mem_ready = mr;
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [20:0] e;
        e = expw(plan[0], reset, opcode, zero, mem_ready);
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s outputs got %h want %h (model state %0d)", tag, act, e, plan[0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(reset, opcode, mem_ready);
        #1;
    endtask

    task automatic add(input logic r, input logic [5:0] op, input logic z, input logic mr,
                       input logic [3:0] st, input logic [3:0] we, input logic pcen, input logic ill);
        vec_t v;
        v.r = r; v.op = op; v.z = z; v.mr = mr; v.st = st; v.we = we; v.pcen = pcen; v.ill = ill;
        tbl.push_back(v);
    endtask

    initial begin
        plan = {0};
        // we = {MemWrite, RegWrite, IRWrite, PCWrite}
        add(1, LW, 0, 1, 0, 4'b0000, 0, 0);
        add(0, LW, 0, 1, 0, 4'b0011, 1, 0);
        add(0, LW, 0, 1, 1, 4'b0000, 0, 0);
        add(0, LW, 0, 1, 2, 4'b0000, 0, 0);
        add(0, LW, 0, 1, 3, 4'b0000, 0, 0);
        add(0, LW, 0, 1, 4, 4'b0100, 0, 0);
        add(0, SW, 0, 1, 0, 4'b0011, 1, 0);
        add(0, SW, 0, 1, 1, 4'b0000, 0, 0);
        add(0, SW, 0, 1, 2, 4'b0000, 0, 0);
        add(0, SW, 0, 0, 5, 4'b1000, 0, 0);
        add(0, SW, 0, 0, 5, 4'b1000, 0, 0);
        add(0, SW, 0, 0, 5, 4'b1000, 0, 0);
        add(0, SW, 0, 1, 5, 4'b1000, 0, 0);
        add(0, BEQ, 1, 1, 0, 4'b0011, 1, 0);
        add(0, BEQ, 1, 1, 1, 4'b0000, 0, 0);
        add(0, BEQ, 1, 1, 8, 4'b0000, 1, 0);
        add(0, BEQ, 0, 1, 0, 4'b0011, 1, 0);
        add(0, BEQ, 0, 1, 1, 4'b0000, 0, 0);
        add(0, BEQ, 0, 1, 8, 4'b0000, 0, 0);
        add(0, BAD, 0, 1, 0, 4'b0011, 1, 0);
        add(0, BAD, 0, 1, 1, 4'b0000, 0, 1);
        add(0, BAD, 0, 0, 0, 4'b0000, 0, 0);
        add(0, BAD, 0, 0, 0, 4'b0000, 0, 0);
        add(0, RT, 0, 1, 0, 4'b0011, 1, 0);
        add(0, RT, 0, 1, 1, 4'b0000, 0, 0);
        add(0, RT, 0, 1, 6, 4'b0000, 0, 0);
        add(0, RT, 0, 1, 7, 4'b0100, 0, 0);
        add(0, LW, 0, 1, 0, 4'b0011, 1, 0);
        add(0, LW, 0, 1, 1, 4'b0000, 0, 0);
        add(0, LW, 0, 1, 2, 4'b0000, 0, 0);
        add(0, LW, 0, 0, 3, 4'b0000, 0, 0);
        add(1, LW, 1, 0, 0, 4'b0000, 0, 0);
        add(1, BAD, 1, 1, 0, 4'b0000, 0, 0);
        add(0, LW, 0, 0, 0, 4'b0000, 0, 0);
        add(0, J, 0, 1, 0, 4'b0011, 1, 0);
        add(0, J, 0, 1, 1, 4'b0000, 0, 0);
        add(0, J, 0, 1, 11, 4'b0001, 1, 0);
        add(0, ADDI, 0, 1, 0, 4'b0011, 1, 0);
        add(0, ADDI, 0, 1, 1, 4'b0000, 0, 0);
        add(0, LW, 0, 1, 9, 4'b0000, 0, 0);
        add(0, SW, 0, 1, 10, 4'b0100, 0, 0);
        add(0, SW, 0, 1, 0, 4'b0011, 1, 0);
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].r, tbl[i].op, tbl[i].z, tbl[i].mr);
            check_model($sformatf("vec%0d", i));
            checks++;
            if (state !== tbl[i].st || {MemWrite, RegWrite, IRWrite, PCWrite} !== tbl[i].we ||
                PCEn !== tbl[i].pcen || illegal_op !== tbl[i].ill) begin
                errors++;
                $display("FAIL vec%0d got st=%0d we=%b pcen=%b ill=%b want st=%0d we=%b pcen=%b ill=%b",
                         i, state, {MemWrite, RegWrite, IRWrite, PCWrite}, PCEn, illegal_op,
                         tbl[i].st, tbl[i].we, tbl[i].pcen, tbl[i].ill);
            end
            tick();
        end
        for (int i = 0; i < 3000; i++) begin
            logic [5:0] op;
            int k;
            k = int'($urandom_range(0, 7));
            op = (k == 0) ? LW : (k == 1) ? SW : (k == 2) ? RT : (k == 3) ? BEQ :
                 (k == 4) ? ADDI : (k == 5) ? J : 6'($urandom);
            drive($urandom_range(0, 63) == 0, op, 1'($urandom), $urandom_range(0, 9) < 7);
            check_model($sformatf("rnd%0d", i));
            tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
